multi_cycle_ctrl: RTL and testbench

- Main sequencer for the multi-cycle core. Steps each instruction through fetch, decode, execute, memory and writeback.
- Drives the instruction-fetch and load/store request handshakes.
- Emits the one-cycle commit pulse that advances the PC register and gates the register-file write.
- Detects bus errors, bus timeouts, illegal instructions and ebreak, and parks the core in a terminal HALT or TRAP state.

---
 rtl/multi_cycle_ctrl.sv | 134 +++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_ctrl.sv
// Main sequencer of the multi-cycle core: fetch/decode/execute/memory/writeback
// with bus handshakes, commit pulse, retire counter and terminal HALT/TRAP.
module multi_cycle_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ifu_req,
  input  logic             ifu_ready,
  input  logic             ifu_rvalid,
  input  logic             ifu_err,
  output logic             inst_we,
  input  logic             decode_i_is_load,
  input  logic             decode_i_is_store,
  input  logic             decode_i_is_ebreak,
  input  logic             decode_i_illegal,
  output logic             lsu_req,
  input  logic             lsu_ready,
  input  logic             lsu_rvalid,
  input  logic             lsu_err,
  output logic             rf_we,
  output logic             commit,
  output logic             halt,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [3:0]       state_o
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_WAIT_I   = 4'd2,
    S_DECODE   = 4'd3,
    S_EXEC     = 4'd4,
    S_MEM_REQ  = 4'd5,
    S_MEM_WAIT = 4'd6,
    S_WB       = 4'd7,
    S_HALT     = 4'd8,
    S_TRAP     = 4'd9
  } state_t;

  localparam logic [1:0] C_FETCH = 2'd1;
  localparam logic [1:0] C_ILL   = 2'd2;
  localparam logic [1:0] C_MEM   = 2'd3;

  state_t      state, state_nx;
  logic [1:0]  cause_q, cause_nx;
  logic [15:0] tmo_cnt;
  logic        tmo_hit;
  logic        mem_op, is_store;

  function automatic logic is_wait(input state_t s);
    return (s == S_FETCH) || (s == S_WAIT_I) || (s == S_MEM_REQ) || (s == S_MEM_WAIT);
  endfunction

  // tmo_cnt holds cycles already spent, so the current cycle is the TIMEOUT-th
  assign tmo_hit = (tmo_cnt == 16'(TIMEOUT - 1));

  always_comb begin
    state_nx = state;
    cause_nx = cause_q;
    case (state)
      S_IDLE:   state_nx = S_FETCH;
      S_FETCH: begin
        if (ifu_ready)    state_nx = S_WAIT_I;
        else if (tmo_hit) begin state_nx = S_TRAP; cause_nx = C_FETCH; end
      end
      S_WAIT_I: begin
        if (ifu_rvalid) begin
          if (ifu_err) begin state_nx = S_TRAP; cause_nx = C_FETCH; end
          else         state_nx = S_DECODE;
        end else if (tmo_hit) begin
          state_nx = S_TRAP; cause_nx = C_FETCH;
        end
      end
      S_DECODE: begin
        if (decode_i_illegal)        begin state_nx = S_TRAP; cause_nx = C_ILL; end
        else if (decode_i_is_ebreak) state_nx = S_HALT;
        else                         state_nx = S_EXEC;
      end
      S_EXEC:   state_nx = mem_op ? S_MEM_REQ : S_WB;
      S_MEM_REQ: begin
        if (lsu_ready)    state_nx = S_MEM_WAIT;
        else if (tmo_hit) begin state_nx = S_TRAP; cause_nx = C_MEM; end
      end
      S_MEM_WAIT: begin
        if (lsu_rvalid) begin
          if (lsu_err) begin state_nx = S_TRAP; cause_nx = C_MEM; end
          else         state_nx = S_WB;
        end else if (tmo_hit) begin
          state_nx = S_TRAP; cause_nx = C_MEM;
        end
      end
      S_WB:     state_nx = S_FETCH;
      S_HALT:   state_nx = S_HALT;
      S_TRAP:   state_nx = S_TRAP;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cause_q    <= 2'd0;
      tmo_cnt    <= 16'd0;
      mem_op     <= 1'b0;
      is_store   <= 1'b0;
      retire_cnt <= '0;
    end else begin
      state   <= state_nx;
      cause_q <= cause_nx;
      if (state_nx != state && is_wait(state_nx)) tmo_cnt <= 16'd0;
      else if (is_wait(state))                   tmo_cnt <= tmo_cnt + 16'd1;
      if (state == S_DECODE) begin
        mem_op   <= decode_i_is_load | decode_i_is_store;
        is_store <= decode_i_is_store;
      end
      if (state == S_WB) retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

  assign ifu_req    = (state == S_FETCH);
  assign inst_we    = (state == S_WAIT_I) && ifu_rvalid && !ifu_err;
  assign lsu_req    = (state == S_MEM_REQ);
  assign commit     = (state == S_WB);
  assign rf_we      = (state == S_WB) && !is_store;
  assign halt       = (state == S_HALT);
  assign trap       = (state == S_TRAP);
  assign trap_cause = cause_q;
  assign state_o    = state;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: ALU/load/store streams, faults,
// timeout, mid-operation reset and retire counter wrap.
module tb_multi_cycle_ctrl;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 4;

  localparam logic [3:0] IDLE = 4'd0, FETCH = 4'd1, WAIT_I = 4'd2, DECODE = 4'd3,
                         EXEC = 4'd4, MEM_REQ = 4'd5, MEM_WAIT = 4'd6, WB = 4'd7,
                         HALT = 4'd8, TRAP = 4'd9;

  logic clk = 1'b0, rst = 1'b1;
  logic ifu_req, ifu_ready, ifu_rvalid, ifu_err, inst_we;
  logic is_load, is_store, is_ebreak, illegal;
  logic lsu_req, lsu_ready, lsu_rvalid, lsu_err;
  logic rf_we, commit, halt, trap;
  logic [1:0] trap_cause;
  logic [CNT_W-1:0] retire_cnt;
  logic [3:0] state_o;

  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  multi_cycle_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .ifu_req(ifu_req), .ifu_ready(ifu_ready), .ifu_rvalid(ifu_rvalid), .ifu_err(ifu_err),
    .inst_we(inst_we),
    .decode_i_is_load(is_load), .decode_i_is_store(is_store),
    .decode_i_is_ebreak(is_ebreak), .decode_i_illegal(illegal),
    .lsu_req(lsu_req), .lsu_ready(lsu_ready), .lsu_rvalid(lsu_rvalid), .lsu_err(lsu_err),
    .rf_we(rf_we), .commit(commit), .halt(halt), .trap(trap),
    .trap_cause(trap_cause), .retire_cnt(retire_cnt), .state_o(state_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs;
    ifu_ready = 0; ifu_rvalid = 0; ifu_err = 0;
    is_load = 0; is_store = 0; is_ebreak = 0; illegal = 0;
    lsu_ready = 0; lsu_rvalid = 0; lsu_err = 0;
  endtask

  // leaves the DUT in IDLE with rst low; the next tick exits IDLE
  task automatic do_reset;
    rst = 1; clr_inputs();
    #1;
    tick(); tick();
    rst = 0;
  endtask

  initial begin
    clr_inputs();
    #1;
    chk("reset_state", 32'(state_o), 32'(IDLE));
    chk("reset_outs", {ifu_req, lsu_req, inst_we, commit, rf_we, halt, trap}, 0);
    chk("reset_cnt", 32'(retire_cnt), 0);
    do_reset();

    // zero-wait ALU stream: commits at cycles 5/10/15 after the IDLE exit
    ifu_ready = 1; ifu_rvalid = 1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk($sformatf("alu_commit_c%0d", k), 32'(commit), 32'(k % 5 == 0));
      chk($sformatf("alu_rfwe_c%0d", k), 32'(rf_we), 32'(k % 5 == 0));
      chk($sformatf("alu_instwe_c%0d", k), 32'(inst_we), 32'(k % 5 == 2));
      if (k == 15) ifu_ready = 0;
    end
    tick();
    chk("alu_back_fetch", 32'(state_o), 32'(FETCH));
    chk("alu_retire3", 32'(retire_cnt), 3);

    // load: ifu_ready late by 2 cycles, lsu_rvalid late by 3
    ifu_rvalid = 0;
    chk("ld_ifureq1", 32'(ifu_req), 1);
    tick();
    chk("ld_ifureq2", 32'(ifu_req), 1);
    tick();
    ifu_ready = 1;
    chk("ld_ifureq3", 32'(ifu_req), 1);
    tick();
    ifu_ready = 0; ifu_rvalid = 1; is_load = 1;
    #1;
    chk("ld_wait_i", 32'(state_o), 32'(WAIT_I));
    chk("ld_ifureq_drop", 32'(ifu_req), 0);
    chk("ld_instwe", 32'(inst_we), 1);
    tick();
    ifu_rvalid = 0;
    chk("ld_decode", 32'(state_o), 32'(DECODE));
    tick();
    is_load = 0;  // decode inputs must be ignored from here on
    chk("ld_exec", 32'(state_o), 32'(EXEC));
    tick();
    chk("ld_lsureq1", 32'(lsu_req), 1);
    chk("ld_no_ifureq", 32'(ifu_req), 0);
    tick();
    chk("ld_lsureq2", 32'(lsu_req), 1);
    lsu_ready = 1;
    tick();
    lsu_ready = 0;
    chk("ld_mem_wait", 32'(state_o), 32'(MEM_WAIT));
    chk("ld_lsureq_drop", 32'(lsu_req), 0);
    tick();
    tick();
    chk("ld_no_early_commit", 32'(commit), 0);
    lsu_rvalid = 1;
    tick();
    lsu_rvalid = 0;
    chk("ld_wb_commit", 32'(commit), 1);
    chk("ld_wb_rfwe", 32'(rf_we), 1);
    tick();
    chk("ld_retire4", 32'(retire_cnt), 4);
    chk("ld_single_commit", 32'(commit), 0);

    // zero-wait store: 7 cycles, rf_we low in WB
    ifu_ready = 1; ifu_rvalid = 1; is_store = 1; lsu_ready = 1; lsu_rvalid = 1;
    for (int k = 0; k < 6; k++) tick();
    chk("st_wb_state", 32'(state_o), 32'(WB));
    chk("st_commit", 32'(commit), 1);
    chk("st_rfwe", 32'(rf_we), 0);
    clr_inputs();
    tick();
    chk("st_retire5", 32'(retire_cnt), 5);

    // fetch timeout: trap exactly TIMEOUT cycles after WAIT_I entry
    do_reset();
    ifu_ready = 1;
    tick(); tick();
    ifu_ready = 0;
    chk("to_entry", 32'(state_o), 32'(WAIT_I));
    for (int k = 0; k < TIMEOUT - 1; k++) tick();
    chk("to_not_yet", 32'(trap), 0);
    tick();
    chk("to_trap", 32'(trap), 1);
    chk("to_cause", 32'(trap_cause), 1);
    tick(); tick();
    chk("to_stays", 32'(state_o), 32'(TRAP));
    chk("to_no_ifureq", 32'(ifu_req), 0);

    // fetch error response
    do_reset();
    ifu_ready = 1; ifu_rvalid = 1; ifu_err = 1;
    tick(); tick();
    chk("ierr_no_instwe", 32'(inst_we), 0);
    tick();
    chk("ierr_trap", {30'd0, trap, halt}, 2);
    chk("ierr_cause", 32'(trap_cause), 1);

    // illegal wins over ebreak
    do_reset();
    ifu_ready = 1; ifu_rvalid = 1; illegal = 1; is_ebreak = 1;
    tick(); tick(); tick(); tick();
    chk("ill_trap", {30'd0, trap, halt}, 2);
    chk("ill_cause", 32'(trap_cause), 2);

    // ebreak only: halt, never commits
    do_reset();
    ifu_ready = 1; ifu_rvalid = 1; is_ebreak = 1;
    tick(); tick(); tick(); tick();
    chk("eb_halt", {30'd0, trap, halt}, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("eb_quiet%0d", k), {commit, rf_we, ifu_req, lsu_req, inst_we}, 0);
    end
    chk("eb_retire0", 32'(retire_cnt), 0);

    // load/store error response
    do_reset();
    ifu_ready = 1; ifu_rvalid = 1; is_load = 1; lsu_ready = 1; lsu_rvalid = 1; lsu_err = 1;
    for (int k = 0; k < 7; k++) tick();
    chk("lerr_trap", 32'(state_o), 32'(TRAP));
    chk("lerr_cause", 32'(trap_cause), 3);

    // reset while lsu_req is high, then 16 retires wrap a 4-bit counter
    do_reset();
    ifu_ready = 1; ifu_rvalid = 1; is_store = 1;
    for (int k = 0; k < 5; k++) tick();
    chk("mr_lsureq", 32'(lsu_req), 1);
    rst = 1;
    #1;
    chk("mr_lsureq_drop", 32'(lsu_req), 0);
    chk("mr_idle", 32'(state_o), 32'(IDLE));
    chk("mr_no_commit", 32'(commit), 0);
    is_store = 0;
    tick();
    rst = 0;
    tick();
    chk("mr_fetch", 32'(state_o), 32'(FETCH));
    chk("mr_retire0", 32'(retire_cnt), 0);
    for (int k = 0; k < 75; k++) tick();
    chk("wrap_15", 32'(retire_cnt), 15);
    for (int k = 0; k < 5; k++) tick();
    chk("wrap_0", 32'(retire_cnt), 0);
    chk("wrap_fetch", 32'(state_o), 32'(FETCH));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end
endmodule
